mul_nbit: RTL and testbench

Multi-cycle SIZE×SIZE integer multiplier for the ALU's M-extension path, the multiplicative counterpart of the iterative divider. It shares the divider's start/ready/valid handshake. It supports unsigned, signed and mixed-sign operands, so one instance serves MUL, MULH, MULHSU and MULHU. The full 2·SIZE-bit product is returned, and the ALU selects the low or high half.

---
 rtl/mul_nbit_pkg.sv | 29 ++
 rtl/mul_unsigned_nbit.sv | 138 +++++++++++++
 rtl/mul_nbit.sv | 60 ++++++
 tb/tb_mul_nbit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_nbit_pkg.sv
// Shared types and helpers for the mul_nbit multiplier.
// MUL_NBIT_RADIX4_EN selects two multiplier bits per CALC cycle.
package mul_nbit_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_CALC = 2'd1,
    STATE_DONE = 2'd2
  } state_e;

  // Operands are extended to this width before taking magnitudes.
  localparam int unsigned ABS_W = 128;

`ifdef MUL_NBIT_RADIX4_EN
  localparam int unsigned BITS_PER_ITER = 2;
`else
  localparam int unsigned BITS_PER_ITER = 1;
`endif

  function automatic int unsigned iter_count(input int unsigned size);
    return size / BITS_PER_ITER;
  endfunction

  function automatic logic [ABS_W-1:0] abs_if_signed(input logic [ABS_W-1:0] value,
                                                     input logic             is_signed);
    return (is_signed && value[ABS_W-1]) ? ('0 - value) : value;
  endfunction

endpackage

// File: rtl/mul_unsigned_nbit.sv
// Unsigned iterative shift-add multiplier core with start/ready/valid handshake.
// MUL_NBIT_RADIX4_EN: two multiplier bits per cycle using a precomputed 3*A.
module mul_unsigned_nbit
  import mul_nbit_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE-1:0]   multiplicand,
  input  logic [SIZE-1:0]   multiplier,
  output logic              ready,
  output logic              valid,
  output logic [2*SIZE-1:0] product
);

  localparam int unsigned ITERS = iter_count(SIZE);
  localparam int unsigned CW    = $clog2(ITERS + 1);

  state_e              state_q, state_d;
  logic [2*SIZE-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SIZE-1:0]     b_q, b_d;
  logic                accept;

`ifdef MUL_NBIT_RADIX4_EN
  logic [SIZE-1:0]     a_q, a_d;
  logic [SIZE+1:0]     a3_q, a3_d;
  logic [SIZE+1:0]     pp;
`else
  logic [2*SIZE-1:0]   a_q, a_d;
`endif

  assign accept = start && (state_q == STATE_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= STATE_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STATE_IDLE: if (start) state_d = STATE_CALC;
      STATE_CALC: if (cnt_q == CW'(ITERS - 1)) state_d = STATE_DONE;
      STATE_DONE: state_d = STATE_IDLE;
      default:    state_d = STATE_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == STATE_IDLE);
    valid = (state_q == STATE_DONE);
  end

`ifdef MUL_NBIT_RADIX4_EN
  always_comb begin
    unique case (b_q[1:0])
      2'b00:   pp = '0;
      2'b01:   pp = {2'b00, a_q};
      2'b10:   pp = {1'b0, a_q, 1'b0};
      default: pp = a3_q;
    endcase
  end

  // A stays unshifted; the partial product is aligned by the iteration count.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    a_d   = a_q;
    a3_d  = a3_q;
    b_d   = b_q;
    if (accept) begin
      acc_d = '0;
      cnt_d = '0;
      a_d   = multiplicand;
      a3_d  = (SIZE+2)'(multiplicand) + {1'b0, multiplicand, 1'b0};
      b_d   = multiplier;
    end else if (state_q == STATE_CALC) begin
      acc_d = acc_q + ((2*SIZE)'(pp) << {cnt_q, 1'b0});
      cnt_d = cnt_q + CW'(1);
      b_d   = b_q >> 2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      a_q   <= '0;
      a3_q  <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      a_q   <= a_d;
      a3_q  <= a3_d;
      b_q   <= b_d;
    end
  end
`else
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    if (accept) begin
      acc_d = '0;
      cnt_d = '0;
      a_d   = (2*SIZE)'(multiplicand);
      b_d   = multiplier;
    end else if (state_q == STATE_CALC) begin
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      cnt_d = cnt_q + CW'(1);
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end
`endif

  assign product = acc_q;

endmodule

// File: rtl/mul_nbit.sv
// Signed/unsigned/mixed SIZE x SIZE multiplier returning the full 2*SIZE product.
// MUL_NBIT_RADIX4_EN halves the CALC phase; results are identical in both builds.
module mul_nbit
  import mul_nbit_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_signed_a,
  input  logic              is_signed_b,
  input  logic [SIZE-1:0]   multiplicand,
  input  logic [SIZE-1:0]   multiplier,
  output logic              ready,
  output logic              valid,
  output logic [2*SIZE-1:0] product
);

  logic [SIZE-1:0]   mag_a, mag_b;
  logic              neg_d, neg_q;
  logic              core_ready, core_valid;
  logic [2*SIZE-1:0] core_acc, result, product_q;

  assign mag_a = SIZE'(abs_if_signed({{(ABS_W-SIZE){is_signed_a & multiplicand[SIZE-1]}},
                                      multiplicand}, is_signed_a));
  assign mag_b = SIZE'(abs_if_signed({{(ABS_W-SIZE){is_signed_b & multiplier[SIZE-1]}},
                                      multiplier}, is_signed_b));
  assign neg_d = (is_signed_a & multiplicand[SIZE-1]) ^ (is_signed_b & multiplier[SIZE-1]);

  mul_unsigned_nbit #(.SIZE(SIZE)) u_core (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (mag_a),
    .multiplier   (mag_b),
    .ready        (core_ready),
    .valid        (core_valid),
    .product      (core_acc)
  );

  assign result = neg_q ? ('0 - core_acc) : core_acc;

  // The core accumulator is final during DONE; capture the signed result there
  // so it stays held across later accepts until the next DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      if (start && core_ready) neg_q <= neg_d;
      if (core_valid)          product_q <= result;
    end
  end

  assign ready   = core_ready;
  assign valid   = core_valid;
  assign product = core_valid ? result : product_q;

endmodule

// File: tb/tb_mul_nbit.sv
// Self-checking bench for mul_nbit: directed vector table, randomized ops
// against an arithmetic reference model, and handshake/reset corner sequences.
module tb_mul_nbit;

`ifdef MUL_NBIT_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset, start, is_signed_a, is_signed_b;
  logic [31:0] multiplicand, multiplier;
  logic        ready, valid;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;

  mul_nbit #(.SIZE(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed_a  (is_signed_a),
    .is_signed_b  (is_signed_b),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .valid        (valid),
    .product      (product)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
    logic signed [65:0] ea, eb, p;
    ea = {{34{sa & a[31]}}, a};
    eb = {{34{sb & b[31]}}, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    is_signed_a  = sa;
    is_signed_b  = sb;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    is_signed_a  = 1'($urandom_range(0, 1));
    is_signed_b  = 1'($urandom_range(0, 1));
  endtask

  // Issue one op and wait (bounded) for its valid pulse; lat = -1 on timeout.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                       input logic sb, output logic [63:0] prod, output int lat);
    issue(a, b, sa, sb);
    lat  = -1;
    prod = 'x;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      if (valid) begin
        lat  = k;
        prod = product;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [63:0] p;
    int          lat;
    do_op(v.a, v.b, v.sa, v.sb, p, lat);
    check({name, " product"}, p, v.exp);
    check({name, " latency"}, 64'(lat), 64'(LAT));
    @(negedge clk);
    check({name, " valid_one_cycle"}, 64'(valid), 64'd0);
    check({name, " ready_back"}, 64'(ready), 64'd1);
    check({name, " product_held"}, product, v.exp);
  endtask

  vec_t vecs[$];

  initial begin
    logic [63:0] p;
    int          lat;
    int          pulses, valid_k, ready_k;
    logic [63:0] storm_prod;

    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0001});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 64'h4000_0000_0000_0000});
    vecs.push_back('{32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
    vecs.push_back('{32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1, 64'h0000_0000_0000_0000});
    vecs.push_back('{32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000});

    reset = 1'b1; start = 1'b0; is_signed_a = 1'b0; is_signed_b = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", 64'(ready), 64'd1);
    check("reset valid", 64'(valid), 64'd0);
    check("reset product", product, 64'd0);

    // Reset and start in the same cycle: request must be dropped.
    multiplicand = 32'd3; multiplier = 32'd5; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("reset_wins ready", 64'(ready), 64'd1);
    pulses = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("reset_wins no_valid", 64'(pulses), 64'd0);
    check("reset_wins product", product, 64'd0);

    for (int i = 0; i < vecs.size(); i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic        sa, sb;
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) b = '0;
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      do_op(a, b, sa, sb, p, lat);
      check($sformatf("rand%0d product", i), p, ref_mul(a, b, sa, sb));
      check($sformatf("rand%0d latency", i), 64'(lat), 64'(LAT));
    end

    // start held high with fresh operands through CALC: only the first op completes.
    issue(32'hFFFF_FFF6, 32'h0000_0007, 1'b1, 1'b1);
    pulses = 0; valid_k = -1; ready_k = -1; storm_prod = 'x;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      if (valid) begin
        pulses++;
        if (valid_k < 0) begin
          valid_k    = k;
          storm_prod = product;
        end
      end
      if (ready && ready_k < 0) ready_k = k;
      if (k < LAT) begin
        start        = 1'b1;
        multiplicand = $urandom;
        multiplier   = $urandom;
        is_signed_a  = 1'($urandom_range(0, 1));
        is_signed_b  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    check("storm pulses", 64'(pulses), 64'd1);
    check("storm valid_cycle", 64'(valid_k), 64'(LAT));
    check("storm ready_cycle", 64'(ready_k), 64'(LAT + 1));
    check("storm product", storm_prod, 64'hFFFF_FFFF_FFFF_FFBA);

    // Reset during CALC: result discarded, outputs back to reset values.
    issue(32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) reset = 1'b1;
    end
    @(negedge clk);
    check("midreset ready", 64'(ready), 64'd1);
    check("midreset valid", 64'(valid), 64'd0);
    check("midreset product", product, 64'd0);
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("midreset no_valid", 64'(pulses), 64'd0);
    do_op(32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, p, lat);
    check("after_reset product", p, 64'd0);
    check("after_reset latency", 64'(lat), 64'(LAT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
